// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL): one register per shift level, valid/ready per stage.
// Optional out_sticky port (OR of all bits shifted off) is enabled by defining SHIFT_PIPE_STICKY_EN.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_PIPE_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  if ((WIDTH & (WIDTH - 1)) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("shift_pipe: WIDTH must be a power of 2 in 8..64");
  end

  // Handshake: a stage loads when it is empty or its content moves on this edge;
  // the last stage moves when out_ready=1. in_ready is the load enable of stage 0.

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] mode, input int k);
    int s;
    s = 1 << k;
    case (mode)
      MODE_SLL: shift_level = d << s;
      MODE_SRL: shift_level = d >> s;
      MODE_SRA: shift_level = $signed(d) >>> s;
      default:  shift_level = (d << s) | (d >> (WIDTH - s));
    endcase
  endfunction

`ifdef SHIFT_PIPE_STICKY_EN
  function automatic logic lost_bits(input logic [WIDTH-1:0] d, input logic [1:0] mode,
                                     input int k);
    int s;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    s       = 1 << k;
    lo_mask = ~({WIDTH{1'b1}} << s);
    hi_mask = ~({WIDTH{1'b1}} >> s);
    case (mode)
      MODE_SLL:           lost_bits = |(d & hi_mask);
      MODE_SRL, MODE_SRA: lost_bits = |(d & lo_mask);
      default:            lost_bits = 1'b0;
    endcase
  endfunction
`endif

  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   stage_en;
  logic [SHW-1:0]   src_valid;
  logic             down_ready;
  logic [WIDTH-1:0] data_q    [SHW];
  logic [WIDTH-1:0] data_d    [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   shamt_q   [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [1:0]       mode_q    [SHW];
  logic [1:0]       src_mode  [SHW];
  logic [TAG_W-1:0] tag_q     [SHW];
  logic [TAG_W-1:0] src_tag   [SHW];
`ifdef SHIFT_PIPE_STICKY_EN
  logic [SHW-1:0]   sticky_q;
  logic [SHW-1:0]   sticky_d;
  logic [SHW-1:0]   src_sticky;
`endif

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_mode[0]  = in_mode;
    src_tag[0]   = in_tag;
    for (int k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      data_d[k] = src_shamt[k][k] ? shift_level(src_data[k], src_mode[k], k) : src_data[k];
    end
  end

`ifdef SHIFT_PIPE_STICKY_EN
  always_comb begin
    src_sticky    = '0;
    src_sticky[0] = 1'b0;
    for (int k = 1; k < SHW; k++) src_sticky[k] = sticky_q[k-1];
    sticky_d = '0;
    for (int k = 0; k < SHW; k++) begin
      sticky_d[k] = src_sticky[k] |
                    (src_shamt[k][k] & lost_bits(src_data[k], src_mode[k], k));
    end
  end
`endif

  // Ready ripples from the consumer back to stage 0, so bubbles collapse without a global stall.
  always_comb begin
    stage_en   = '0;
    down_ready = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      stage_en[k] = ~valid_q[k] | down_ready;
      down_ready  = stage_en[k];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
`ifdef SHIFT_PIPE_STICKY_EN
      sticky_q <= '0;
`endif
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (stage_en[k]) begin
          valid_q[k] <= src_valid[k];
          // Payload only moves with a valid op; bubbles leave the data registers untouched.
          if (src_valid[k]) begin
            data_q[k]  <= data_d[k];
            shamt_q[k] <= src_shamt[k];
            mode_q[k]  <= src_mode[k];
            tag_q[k]   <= src_tag[k];
`ifdef SHIFT_PIPE_STICKY_EN
            sticky_q[k] <= sticky_d[k];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = stage_en[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];
`ifdef SHIFT_PIPE_STICKY_EN
  assign out_sticky = sticky_q[SHW-1];
`endif

  // Shift-amount bits already consumed and the last stage's mode are carried but never read.
  logic lint_unused;
  always_comb begin
    lint_unused = ^mode_q[SHW-1];
    for (int k = 0; k < SHW; k++) lint_unused = lint_unused ^ (^shamt_q[k]);
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed steps plus random traffic against a
// whole-shift reference model and an expected-result queue.
module tb_shift_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int TAG_W = 5;
  localparam int LAT   = SHW;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef SHIFT_PIPE_STICKY_EN
  logic             out_sticky;
  logic             stk_q[$];
  logic             last_sticky;
`endif

  int checks = 0;
  int errors = 0;
  int in_fires = 0;

  logic [TAG_W+WIDTH-1:0] exp_q[$];
  logic                   hold_pending;
  logic [WIDTH-1:0]       hold_data;
  logic [TAG_W-1:0]       hold_tag;
  logic [WIDTH-1:0]       last_out_data;
  logic [TAG_W-1:0]       last_out_tag;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef SHIFT_PIPE_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the whole shift done at once on a 64-bit value
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SHW-1:0] sh,
                                                 input logic [1:0] m);
    longint unsigned u;
    longint          s;
    int              n;
    u = 64'(d);
    n = int'(sh);
    case (m)
      2'b00: u = u << n;
      2'b01: u = u >> n;
      2'b10: begin
        if (d[WIDTH-1]) u = u | ~((64'd1 << WIDTH) - 64'd1);
        s = signed'(u);
        s = s >>> n;
        u = unsigned'(s);
      end
      default: u = (u << n) | (u >> (WIDTH - n));
    endcase
    return u[WIDTH-1:0];
  endfunction

  function automatic logic ref_sticky(input logic [WIDTH-1:0] d,
                                      input logic [SHW-1:0] sh,
                                      input logic [1:0] m);
    longint unsigned u;
    int              n;
    u = 64'(d);
    n = int'(sh);
    if (n == 0 || m == 2'b11) return 1'b0;
    if (m == 2'b00) return (u >> (WIDTH - n)) != 64'd0;
    return (u & ((64'd1 << n) - 64'd1)) != 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Driver + scoreboard: one call per clock cycle, inputs at negedge, sampling 1ns later
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                      input logic [1:0] m, input logic [TAG_W-1:0] t, input logic r);
    logic [TAG_W+WIDTH-1:0] e;
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    in_shamt  = sh;
    in_mode   = m;
    in_tag    = t;
    out_ready = r;
    #1;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_data);
      check("hold_tag", out_tag, hold_tag);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[WIDTH-1:0]);
        check("out_tag", out_tag, e[TAG_W+WIDTH-1:WIDTH]);
        last_out_data = out_data;
        last_out_tag  = out_tag;
`ifdef SHIFT_PIPE_STICKY_EN
        check("out_sticky", out_sticky, stk_q.pop_front());
        last_sticky = out_sticky;
`endif
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back({t, ref_shift(d, sh, m)});
`ifdef SHIFT_PIPE_STICKY_EN
      stk_q.push_back(ref_sticky(d, sh, m));
`endif
      in_fires++;
    end
    hold_pending = out_valid && !out_ready;
    hold_data    = out_data;
    hold_tag     = out_tag;
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, '0, 2'b00, '0, r);
  endtask

  // One op into an empty pipe; checks latency, result and tag
  task automatic run_single(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                            input logic [1:0] m, input logic [TAG_W-1:0] t,
                            input logic [WIDTH-1:0] exp);
    step(1'b1, d, sh, m, t, 1'b1);
    check("single_in_ready", in_ready, 1);
    for (int i = 1; i <= LAT; i++) begin
      idle(1'b1);
      check("latency_valid", out_valid, (i == LAT) ? 64'd1 : 64'd0);
    end
    check("single_data", last_out_data, exp);
    check("single_tag", last_out_tag, t);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_shamt     = '0;
    in_mode      = '0;
    in_tag       = '0;
    out_ready    = 1'b0;
    hold_pending = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed single ops and boundaries
    run_single(32'h0000_0001, 5'd31, 2'b00, 5'd7, 32'h8000_0000);
    run_single(32'h8000_00F0, 5'd4, 2'b10, 5'd1, 32'hF800_000F);
    run_single(32'h8000_00F0, 5'd4, 2'b01, 5'd2, 32'h0800_000F);
    run_single(32'h8000_0001, 5'd1, 2'b11, 5'd3, 32'h0000_0003);
    run_single(32'hFFFF_FFFF, 5'd31, 2'b00, 5'd4, 32'h8000_0000);
    run_single(32'h8000_0000, 5'd31, 2'b10, 5'd5, 32'hFFFF_FFFF);
    run_single(32'hA5C3_0F96, 5'd0, 2'b00, 5'd6, 32'hA5C3_0F96);
    run_single(32'hA5C3_0F96, 5'd0, 2'b10, 5'd8, 32'hA5C3_0F96);
    run_single(32'hA5C3_0F96, 5'd0, 2'b11, 5'd9, 32'hA5C3_0F96);

`ifdef SHIFT_PIPE_STICKY_EN
    run_single(32'h0000_0013, 5'd2, 2'b01, 5'd10, 32'h0000_0004);
    check("sticky_set", last_sticky, 1);
    run_single(32'h0000_0010, 5'd2, 2'b01, 5'd11, 32'h0000_0004);
    check("sticky_clear", last_sticky, 0);
    run_single(32'hFFFF_FFFF, 5'd7, 2'b11, 5'd12, 32'hFFFF_FFFF);
    check("sticky_rol", last_sticky, 0);
`endif

    // Back-to-back: 8 ops, results on 8 consecutive cycles
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, 5'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
           5'(i), 1'b1);
      if (i >= LAT) check("b2b_valid", out_valid, 1);
    end
    for (int i = 8; i < 14; i++) begin
      idle(1'b1);
      check("b2b_valid", out_valid, (i < 8 + LAT) ? 64'd1 : 64'd0);
    end
    check("b2b_empty", exp_q.size(), 0);

    // Backpressure: fill with out_ready=0, then release and toggle
    in_fires = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, $urandom, 5'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), 1'b0);
    check("full_accepts", in_fires, LAT);
    check("full_in_ready", in_ready, 0);
    step(1'b1, $urandom, 5'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
         5'($urandom_range(0, 31)), 1'b1);
    check("release_in_ready", in_ready, 1);
    for (int i = 0; i < 40; i++)
      step(1'b1, $urandom, 5'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, WIDTH - 1)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 2) != 0));
    drain();

    // Asynchronous reset with ops in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 5'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
           5'(20 + i), 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_tag", out_tag, 0);
    exp_q.delete();
`ifdef SHIFT_PIPE_STICKY_EN
    stk_q.delete();
`endif
    hold_pending = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle(1'b1);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit logical-left shifter.
- Adds selectable shift modes (SLL/SRL/SRA/ROL), generic width, and one register per shift level.
- Uses a valid/ready handshake with per-stage backpressure.
- Sits between the ALU issue logic and writeback. It also serves the multi-cycle multdiv unit, which needs shifts at full clock rate.

Parameters:
- WIDTH, 32: data width in bits. Must be a power of 2, range 8..64.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- TAG_W, 5: width of the opaque tag (destination register id) carried alongside the data.

Ports:
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input operation present.
- in_ready, out, 1: the shifter accepts the operation this cycle.
- in_data, in, WIDTH: operand.
- in_shamt, in, SHW: shift amount, 0..WIDTH-1.
- in_mode, in, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag, in, TAG_W: tag, returned unchanged.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, WIDTH: shifted result.
- out_tag, out, TAG_W: tag of the result.

Behaviour:
Reset and clocking:
- Clock is "clock". Reset "reset_n" is asynchronous and active-low.
- While reset_n=0, all stage valid bits clear, out_valid=0, out_data=0, out_tag=0.
- in_ready is combinational. After reset it is 1 (pipeline empty).

Pipeline structure:
- SHW stages. Stage k (k=0..SHW-1) applies a shift of 2^k when shamt[k]=1; otherwise it passes data through.
- Stage k's result is registered at the end of stage k. Stage SHW-1 drives out_*.
- Each stage register holds: valid, data, remaining shamt bits, mode, tag.

Latency and throughput:
- Latency is exactly SHW cycles from the accept edge to out_valid, with no stalls. For WIDTH=32 this is 5 cycles.
- Throughput is 1 op/cycle.

Mode semantics, per level:
- SLL: zero fill on the right.
- SRL: zero fill on the left.
- SRA: MSB fill on the left (sign of the original operand, which is preserved level to level).
- ROL: bits leaving the MSB re-enter at the LSB.

Handshake:
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stage k advances when its successor is empty or the successor itself advances. The last stage's successor is the consumer (out_ready).
- in_ready = stage0 empty OR stage0 advancing. Bubbles collapse; there is no global stall.
- out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- in_valid=0 inserts a bubble. An empty stage does not change its data register (low power).

Boundary conditions:
- shamt=0 in any mode: out_data = in_data.
- shamt=WIDTH-1 (SLL): only the LSB survives, at the MSB.
- SRA on a negative operand with shamt=WIDTH-1: all ones.
- Pipeline full with out_ready=0: in_ready=0. The first cycle out_ready=1, all stages shift and in_ready=1 in that same cycle.
- Simultaneous input and output transfer on a full pipe: no loss, no duplicate.
- reset_n asserted mid-operation: all in-flight ops are discarded immediately and out_valid drops asynchronously.
- Illegal WIDTH (not a power of 2): elaboration error via generate-time check.

Optional Feature:
- Macro: SHIFT_PIPE_STICKY_EN.
- When defined:
  - Adds output port out_sticky (1 bit): the OR of every bit shifted off the end across all levels.
  - Accumulated per stage, registered with the data. Reset value 0.
  - Forced to 0 for ROL. Used by FP normalisation.
- When undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
1. WIDTH=32, SLL, data 0x0000_0001, shamt 31, tag 7, out_ready=1 -> out_data 0x8000_0000, tag 7, out_valid exactly 5 cycles after accept.
2. SRA, data 0x8000_00F0, shamt 4 -> 0xF800_000F. Then SRL with the same inputs -> 0x0800_000F. Then ROL, data 0x8000_0001, shamt 1 -> 0x0000_0003.
3. Back-to-back: 8 consecutive ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, tags 0..7 matching.
4. Backpressure: fill the pipe with out_ready=0 -> in_ready=0 after 5 accepted ops. Toggle out_ready 1/0 -> no result lost or duplicated, out_data stable while stalled.
5. Reset: pull reset_n low with 3 ops in flight -> out_valid=0 in the same cycle. Release -> in_ready=1, no stale outputs.
6. Sticky (macro on): SRL, data 0x0000_0013, shamt 2 -> out_data 0x0000_0004, out_sticky 1. SRL, data 0x0000_0010, shamt 2 -> sticky 0. ROL with any input -> sticky 0.
